// File: rtl/iob_sram_ctrl.sv
// IOb-to-SRAM bridge, one request in flight; byte parity built when IOB_SRAM_CTRL_PARITY_EN is defined.
// Latency: ready_o pulses 2 cycles after acceptance for writes, 2+RD_LAT cycles for reads.
// Backpressure: no stall path; requests offered outside IDLE are dropped, so hold valid_i until ready_o.
module iob_sram_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 1,
`ifdef IOB_SRAM_CTRL_PARITY_EN
  localparam int SW        = DATA_W + DATA_W / 8
`else
  localparam int SW        = DATA_W
`endif
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  valid_i,
  input  logic [ADDR_W-1:0]     address_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  ready_o,
  output logic                  par_err_o,
  output logic                  sram_en_o,
  output logic [DATA_W/8-1:0]   sram_we_o,
  output logic [MEM_ADDR_W-1:0] sram_addr_o,
  output logic [SW-1:0]         sram_d_o,
  input  logic [SW-1:0]         sram_q_i
);
  localparam int         NB   = DATA_W / 8;
  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [1:0]            cnt;
  logic                  last_wait;
  logic                  unused_addr;

  // Byte-offset and wrap-around bits of the address are intentionally dropped.
  assign unused_addr = ^address_i;
  assign last_wait   = (state == WAIT) && (cnt == LAST);

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && valid_i) begin
        addr_q  <= address_i[MEM_ADDR_W+1:2];
        data_q  <= wdata_i;
        wstrb_q <= wstrb_i;
        rdata_q <= '0;
        cnt     <= '0;
      end else if (last_wait) begin
        rdata_q <= sram_q_i[DATA_W-1:0];
      end else if (state == WAIT) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    rdata_o     = '0;
    sram_en_o   = 1'b0;
    sram_we_o   = '0;
    sram_addr_o = addr_q;
    case (state)
      IDLE: begin
        if (valid_i) state_nxt = ACCESS;
      end
      ACCESS: begin
        sram_en_o = 1'b1;
        sram_we_o = wstrb_q;
        state_nxt = (wstrb_q == '0) ? WAIT : DONE;
      end
      WAIT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        ready_o   = 1'b1;
        rdata_o   = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IOB_SRAM_CTRL_PARITY_EN
  logic [NB-1:0] wpar;
  logic [NB-1:0] qerr;
  logic          perr_q;

  // Even parity: each stored byte plus its parity bit holds an even number of ones.
  always_comb begin
    wpar = '0;
    qerr = '0;
    for (int i = 0; i < NB; i++) begin
      wpar[i] = ^data_q[8*i +: 8];
      qerr[i] = ^{sram_q_i[8*i +: 8], sram_q_i[DATA_W+i]};
    end
  end

  assign sram_d_o = {wpar, data_q};

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      perr_q <= 1'b0;
    end else if (state == IDLE && valid_i) begin
      perr_q <= 1'b0;
    end else if (last_wait) begin
      perr_q <= |qerr;
    end
  end

  assign par_err_o = ready_o & perr_q;
`else
  assign sram_d_o  = data_q;
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_sram_ctrl.sv
// Randomized bench for iob_sram_ctrl: behavioural SRAM with RD_LAT pipeline plus a word-array reference model.
// Works with IOB_SRAM_CTRL_PARITY_EN defined or undefined.
module tb_iob_sram_ctrl;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_ADDR_W = 10;
  localparam int RD_LAT     = 3;
  localparam int NB         = DATA_W / 8;
  localparam int MEM_WORDS  = 1 << MEM_ADDR_W;
`ifdef IOB_SRAM_CTRL_PARITY_EN
  localparam int SW         = DATA_W + NB;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int SW         = DATA_W;
  localparam bit PAR_EN     = 1'b0;
`endif
  localparam int FLIP_BIT   = PAR_EN ? DATA_W + 1 : 0;

  logic                  clk = 1'b0;
  logic                  arst = 1'b0;
  logic                  valid = 1'b0;
  logic [ADDR_W-1:0]     address = '0;
  logic [DATA_W-1:0]     wdata = '0;
  logic [NB-1:0]         wstrb = '0;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic                  par_err;
  logic                  sram_en;
  logic [NB-1:0]         sram_we;
  logic [MEM_ADDR_W-1:0] sram_addr;
  logic [SW-1:0]         sram_d;
  logic [SW-1:0]         sram_q;

  int vectors = 0;
  int miscompares = 0;

  iob_sram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk), .arst_i(arst), .valid_i(valid), .address_i(address),
    .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rdata), .ready_o(ready),
    .par_err_o(par_err), .sram_en_o(sram_en), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_d_o(sram_d), .sram_q_i(sram_q)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-enabled writes, read data appears RD_LAT cycles after the enable edge.
  logic [SW-1:0] mem [MEM_WORDS] = '{default: '0};
  logic [SW-1:0] rd_pipe [RD_LAT] = '{default: '0};
  int            wr_count = 0;
  logic          flip_req = 1'b0;

  always @(posedge clk) begin
    if (sram_en) begin
      rd_pipe[0] <= mem[sram_addr];
      for (int b = 0; b < NB; b++) begin
        if (sram_we[b]) begin
          mem[sram_addr][8*b +: 8] <= sram_d[8*b +: 8];
`ifdef IOB_SRAM_CTRL_PARITY_EN
          mem[sram_addr][DATA_W+b] <= sram_d[DATA_W+b];
`endif
        end
      end
      if (sram_we != '0) wr_count <= wr_count + 1;
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (flip_req && PAR_EN) mem[4][FLIP_BIT] <= ~mem[4][FLIP_BIT];
  end
  assign sram_q = rd_pipe[RD_LAT-1];

  // Reference model: what each word should contain, by byte-address arithmetic.
  logic [DATA_W-1:0] exp_mem [MEM_WORDS] = '{default: '0};

  typedef struct {
    int                    lat;
    logic [DATA_W-1:0]     rdata;
    logic                  perr;
    logic                  acc_en;
    logic [MEM_ADDR_W-1:0] acc_addr;
    logic [NB-1:0]         acc_we;
    logic [SW-1:0]         acc_d;
    int                    stray;
  } obs_t;

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = a / 32'd4;
    return int'(w % 32'(MEM_WORDS));
  endfunction

  function automatic logic [SW-1:0] exp_sram_d(input logic [DATA_W-1:0] d);
    logic [SW-1:0] r;
    r = '0;
    r[DATA_W-1:0] = d;
`ifdef IOB_SRAM_CTRL_PARITY_EN
    for (int b = 0; b < NB; b++) r[DATA_W+b] = ($countones(d[8*b +: 8]) % 2) == 1;
`endif
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] s);
    int idx;
    idx = word_idx(a);
    for (int b = 0; b < NB; b++) if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  // Issues one request in an IDLE cycle and records what the controller did; garbage is driven while busy.
  task automatic run_req(input logic [31:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] s,
                         output obs_t o);
    o.lat = -1; o.rdata = '0; o.perr = 1'b0; o.acc_en = 1'b0;
    o.acc_addr = '0; o.acc_we = '0; o.acc_d = '0; o.stray = 0;
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) begin
        o.acc_en = sram_en; o.acc_addr = sram_addr; o.acc_we = sram_we; o.acc_d = sram_d;
      end else if (sram_en || sram_we != '0) begin
        o.stray++;
      end
      if (ready) begin
        o.lat = n; o.rdata = rdata; o.perr = par_err;
      end else if (rdata != '0 || par_err) begin
        o.stray++;
      end
      valid = 1'($urandom_range(0, 1)); address = $urandom; wdata = $urandom; wstrb = NB'($urandom);
      if (ready) break;
    end
  endtask

  task automatic test_reset();
    arst = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
    vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
    vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL reset_perr got %b want 0", par_err); end
    vectors++; if (sram_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", sram_en); end
    vectors++; if (sram_we !== '0) begin miscompares++; $display("FAIL reset_we got %h want 0", sram_we); end
    vectors++; if (sram_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    arst = 1'b1;
    @(negedge clk);
    vectors++; if (ready !== 1'b0 || sram_en !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got rdy=%b en=%b want 0 0", ready, sram_en); end
  endtask

  task automatic test_directed();
    obs_t o;
    run_req(32'h10, 32'hDEADBEEF, 4'hF, o);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL wr_lat got %0d want 2", o.lat); end
    vectors++; if (o.acc_en !== 1'b1) begin miscompares++; $display("FAIL wr_access_en got %b want 1", o.acc_en); end
    vectors++; if (o.acc_addr !== 10'd4) begin miscompares++; $display("FAIL wr_addr got %0d want 4", o.acc_addr); end
    vectors++; if (o.acc_we !== 4'hF) begin miscompares++; $display("FAIL wr_we got %h want f", o.acc_we); end
    vectors++; if (o.acc_d !== exp_sram_d(32'hDEADBEEF)) begin miscompares++; $display("FAIL wr_d got %h want %h", o.acc_d, exp_sram_d(32'hDEADBEEF)); end
    vectors++; if (o.rdata !== '0 || o.perr !== 1'b0) begin miscompares++; $display("FAIL wr_rdata got %h/%b want 0/0", o.rdata, o.perr); end
    run_req(32'h10, $urandom, 4'h0, o);
    vectors++; if (o.lat !== 2 + RD_LAT) begin miscompares++; $display("FAIL rd_lat got %0d want %0d", o.lat, 2 + RD_LAT); end
    vectors++; if (o.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", o.rdata); end
    vectors++; if (o.perr !== 1'b0) begin miscompares++; $display("FAIL rd_perr got %b want 0", o.perr); end
    vectors++; if (o.acc_we !== 4'h0 || o.stray !== 0) begin miscompares++; $display("FAIL rd_we_stray got we=%h stray=%0d want 0 0", o.acc_we, o.stray); end
    run_req(32'h10, 32'h000000AA, 4'h1, o);
    model_write(32'h10, 32'h000000AA, 4'h1);
    vectors++; if (o.acc_we !== 4'h1) begin miscompares++; $display("FAIL partial_we got %h want 1", o.acc_we); end
    run_req(32'h10, $urandom, 4'h0, o);
    vectors++; if (o.rdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL partial_rd got %h want deadbeaa", o.rdata); end
    run_req(32'h1010, $urandom, 4'h0, o);
    vectors++; if (o.acc_addr !== 10'd4) begin miscompares++; $display("FAIL wrap_addr got %0d want 4", o.acc_addr); end
    vectors++; if (o.rdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL wrap_rd got %h want deadbeaa", o.rdata); end
  endtask

  task automatic test_parity();
    obs_t o;
    @(negedge clk); valid = 1'b0; flip_req = 1'b1;
    @(negedge clk); flip_req = 1'b0;
    run_req(32'h10, $urandom, 4'h0, o);
    vectors++; if (o.perr !== PAR_EN) begin miscompares++; $display("FAIL par_inject got %b want %b", o.perr, PAR_EN); end
    vectors++; if (o.rdata !== exp_mem[4] || o.lat !== 2 + RD_LAT) begin miscompares++; $display("FAIL par_inject_rd got %h lat %0d want %h lat %0d", o.rdata, o.lat, exp_mem[4], 2 + RD_LAT); end
    @(negedge clk); valid = 1'b0; flip_req = 1'b1;
    @(negedge clk); flip_req = 1'b0;
    run_req(32'h10, $urandom, 4'h0, o);
    vectors++; if (o.perr !== 1'b0) begin miscompares++; $display("FAIL par_restored got %b want 0", o.perr); end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    int w0;
    logic en_seen;
    logic rdy_seen;
    idle(1);
    w0 = wr_count;
    @(negedge clk); valid = 1'b1; address = 32'h20; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    @(negedge clk);
    en_seen = sram_en;
    arst = 1'b0; valid = 1'b0;
    #1;
    vectors++; if (en_seen !== 1'b1) begin miscompares++; $display("FAIL rstw_access got %b want 1", en_seen); end
    vectors++; if (sram_en !== 1'b0 || sram_we !== '0) begin miscompares++; $display("FAIL rstw_immediate got en=%b we=%h want 0 0", sram_en, sram_we); end
    rdy_seen = 1'b0;
    repeat (2) begin @(negedge clk); rdy_seen |= ready; end
    arst = 1'b1;
    repeat (3) begin @(negedge clk); rdy_seen |= ready; end
    vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL rstw_ready got %b want 0", rdy_seen); end
    vectors++; if (wr_count !== w0) begin miscompares++; $display("FAIL rstw_writes got %0d want %0d", wr_count, w0); end
    run_req(32'h20, $urandom, 4'h0, o);
    vectors++; if (o.rdata !== exp_mem[8]) begin miscompares++; $display("FAIL rstw_mem got %h want %h", o.rdata, exp_mem[8]); end
  endtask

  task automatic test_reset_mid_read();
    int w0;
    int lat;
    logic en1;
    logic [MEM_ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] rd;
    logic rdy_seen;
    idle(1);
    w0 = wr_count;
    @(negedge clk); valid = 1'b1; address = 32'h10; wdata = $urandom; wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    vectors++; if (ready !== 1'b0 || rdata !== '0 || par_err !== 1'b0) begin miscompares++; $display("FAIL rstr_outs got rdy=%b rd=%h pe=%b want 0", ready, rdata, par_err); end
    vectors++; if (sram_en !== 1'b0 || sram_addr !== '0) begin miscompares++; $display("FAIL rstr_sram got en=%b addr=%h want 0 0", sram_en, sram_addr); end
    rdy_seen = 1'b0;
    repeat (3) begin @(negedge clk); rdy_seen |= ready; end
    vectors++; if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL rstr_ready got %b want 0", rdy_seen); end
    arst = 1'b1;
    lat = -1; en1 = 1'b0; addr1 = '0; rd = '0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) begin en1 = sram_en; addr1 = sram_addr; end
      if (ready) begin lat = n; rd = rdata; valid = 1'b0; break; end
    end
    vectors++; if (en1 !== 1'b1 || addr1 !== 10'd4) begin miscompares++; $display("FAIL rstr_fresh got en=%b addr=%0d want 1 4", en1, addr1); end
    vectors++; if (lat !== 2 + RD_LAT) begin miscompares++; $display("FAIL rstr_lat got %0d want %0d", lat, 2 + RD_LAT); end
    vectors++; if (rd !== exp_mem[4]) begin miscompares++; $display("FAIL rstr_rdata got %h want %h", rd, exp_mem[4]); end
    vectors++; if (wr_count !== w0) begin miscompares++; $display("FAIL rstr_writes got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] a;
    logic [DATA_W-1:0] d;
    logic [NB-1:0] s;
    logic [DATA_W-1:0] exp_rd;
    int idx;
    int exp_lat;
    for (int i = 0; i < 150; i++) begin
      idle($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[11:2] = 10'($urandom_range(0, 15));
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? '0 : NB'($urandom_range(1, 15));
      idx = word_idx(a);
      exp_rd  = (s == '0) ? exp_mem[idx] : '0;
      exp_lat = (s == '0) ? 2 + RD_LAT : 2;
      run_req(a, d, s, o);
      model_write(a, d, s);
      vectors++; if (o.lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d lat got %0d want %0d", i, o.lat, exp_lat); end
      vectors++; if (o.rdata !== exp_rd) begin miscompares++; $display("FAIL rnd%0d rdata got %h want %h", i, o.rdata, exp_rd); end
      vectors++; if (o.perr !== 1'b0) begin miscompares++; $display("FAIL rnd%0d perr got %b want 0", i, o.perr); end
      vectors++; if (o.acc_en !== 1'b1 || o.acc_addr !== MEM_ADDR_W'(idx)) begin miscompares++; $display("FAIL rnd%0d access got en=%b addr=%0d want 1 %0d", i, o.acc_en, o.acc_addr, idx); end
      vectors++; if (o.acc_we !== s || o.acc_d !== exp_sram_d(d)) begin miscompares++; $display("FAIL rnd%0d we_d got %h/%h want %h/%h", i, o.acc_we, o.acc_d, s, exp_sram_d(d)); end
      vectors++; if (o.stray !== 0) begin miscompares++; $display("FAIL rnd%0d stray got %0d want 0", i, o.stray); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] a;
    logic [DATA_W-1:0] d;
    logic [NB-1:0] s;
    for (int i = 0; i < 8; i++) begin
      a = {20'($urandom), 10'($urandom_range(16, 31)), 2'($urandom)};
      d = $urandom;
      s = NB'($urandom_range(1, 15));
      run_req(a, d, s, o);
      model_write(a, d, s);
      vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL b2b%0d wr_lat got %0d want 2", i, o.lat); end
      run_req(a ^ 32'hFFFF_F003, $urandom, '0, o);
      vectors++; if (o.rdata !== exp_mem[word_idx(a)] || o.lat !== 2 + RD_LAT) begin miscompares++; $display("FAIL b2b%0d rd got %h lat %0d want %h lat %0d", i, o.rdata, o.lat, exp_mem[word_idx(a)], 2 + RD_LAT); end
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_parity();
    test_reset_mid_write();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
